// File: rtl/cv32e40s_clic_arbiter_pkg.sv
// Shared types and constants for the CLIC interrupt arbiter.
package cv32e40s_clic_arbiter_pkg;

  localparam int unsigned CLIC_CFG_WIDTH = 11;
  localparam logic [1:0]  CLIC_PRIV_M    = 2'b11;

  // Field order matches the configuration write word: [10] edge, [9] shv, [8] ie, [7:0] level.
  // 'edge' is a reserved word, hence edge_trig.
  typedef struct packed {
    logic       edge_trig;
    logic       shv;
    logic       ie;
    logic [7:0] level;
  } clic_src_cfg_t;

  function automatic clic_src_cfg_t clic_cfg_unpack(input logic [CLIC_CFG_WIDTH-1:0] wdata);
    return clic_src_cfg_t'(wdata);
  endfunction

endpackage

// File: rtl/cv32e40s_clic_max_tree.sv
// Combinational max-level tree: picks the candidate with the highest level,
// breaking ties towards the highest ID.
module cv32e40s_clic_max_tree #(
  parameter int unsigned NUM_IRQ  = 32,
  parameter int unsigned ID_WIDTH = 5
) (
  input  logic [NUM_IRQ-1:0]      cand_i,
  input  logic [NUM_IRQ-1:0][7:0] level_i,
  output logic                    valid_o,
  output logic [ID_WIDTH-1:0]     id_o,
  output logic [7:0]              level_o
);

  localparam int unsigned LEAVES = 1 << ID_WIDTH;

  // Heap-ordered nodes: node n has children 2n (lower IDs) and 2n+1 (higher IDs).
  logic [2*LEAVES-1:1] node_vld;
  logic [7:0]          node_lvl [2*LEAVES-1:1];
  logic [ID_WIDTH-1:0] node_id  [2*LEAVES-1:1];

  // Fill the leaves, then reduce pairwise towards the root.
  always_comb begin
    node_vld = '0;
    node_lvl = '{default: '0};
    node_id  = '{default: '0};
    for (int unsigned i = 0; i < LEAVES; i++) begin
      node_id[LEAVES+i] = ID_WIDTH'(i);
    end
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      node_vld[LEAVES+i] = cand_i[i];
      node_lvl[LEAVES+i] = level_i[i];
    end
    // The right subtree always holds higher IDs, so ">=" resolves ties to the higher ID.
    for (int unsigned n = LEAVES - 1; n >= 1; n--) begin
      if (node_vld[2*n+1] && (!node_vld[2*n] || (node_lvl[2*n+1] >= node_lvl[2*n]))) begin
        node_vld[n] = 1'b1;
        node_lvl[n] = node_lvl[2*n+1];
        node_id[n]  = node_id[2*n+1];
      end else begin
        node_vld[n] = node_vld[2*n];
        node_lvl[n] = node_lvl[2*n];
        node_id[n]  = node_id[2*n];
      end
    end
  end

  assign valid_o = node_vld[1];
  assign id_o    = node_id[1];
  assign level_o = node_lvl[1];

endmodule

// File: rtl/cv32e40s_clic_arbiter.sv
// CLIC interrupt arbiter: per-source config and pending state, registered
// highest-level/highest-ID winner presented to the core every cycle.
module cv32e40s_clic_arbiter
  import cv32e40s_clic_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IRQ       = 32,
  parameter int unsigned CLIC_ID_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IRQ-1:0]        irq_src_i,
  input  logic                      cfg_we_i,
  input  logic [CLIC_ID_WIDTH-1:0]  cfg_id_i,
  input  logic [CLIC_CFG_WIDTH-1:0] cfg_wdata_i,
  input  logic                      irq_ack_i,
  input  logic [CLIC_ID_WIDTH-1:0]  irq_ack_id_i,
  output logic                      clic_irq_o,
  output logic [CLIC_ID_WIDTH-1:0]  clic_irq_id_o,
  output logic [7:0]                clic_irq_level_o,
  output logic [1:0]                clic_irq_priv_o,
  output logic                      clic_irq_shv_o
);

  clic_src_cfg_t [NUM_IRQ-1:0] cfg_q, cfg_d;
  logic [NUM_IRQ-1:0]          pend_q, pend_d;
  logic [NUM_IRQ-1:0]          src_q;
  logic [NUM_IRQ-1:0]          cand;
  logic [NUM_IRQ-1:0][7:0]     level_vec;

  logic                     win_vld;
  logic [CLIC_ID_WIDTH-1:0] win_id;
  logic [7:0]               win_lvl;
  logic                     win_shv;

  // Next config and edge-pending state; pend_q only carries state for edge sources.
  always_comb begin
    cfg_d  = cfg_q;
    pend_d = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (cfg_q[i].edge_trig) begin
        pend_d[i] = (pend_q[i] & ~(irq_ack_i && (irq_ack_id_i == CLIC_ID_WIDTH'(i))))
                  | (irq_src_i[i] & ~src_q[i]);
      end
      // IDs at or above NUM_IRQ never match any i, so such writes fall through.
      if (cfg_we_i && (cfg_id_i == CLIC_ID_WIDTH'(i))) begin
        cfg_d[i] = clic_cfg_unpack(cfg_wdata_i);
        if (cfg_d[i].edge_trig != cfg_q[i].edge_trig) begin
          pend_d[i] = 1'b0;
        end
      end
    end
  end

  // Candidates: level sources use the registered sample directly as pending.
  always_comb begin
    cand      = '0;
    level_vec = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      cand[i]      = (cfg_q[i].edge_trig ? pend_q[i] : src_q[i]) & cfg_q[i].ie & (|cfg_q[i].level);
      level_vec[i] = cfg_q[i].level;
    end
  end

  cv32e40s_clic_max_tree #(
    .NUM_IRQ  (NUM_IRQ),
    .ID_WIDTH (CLIC_ID_WIDTH)
  ) u_max_tree (
    .cand_i  (cand),
    .level_i (level_vec),
    .valid_o (win_vld),
    .id_o    (win_id),
    .level_o (win_lvl)
  );

  // Look up the vectoring bit of the winning source.
  always_comb begin
    win_shv = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (win_id == CLIC_ID_WIDTH'(i)) begin
        win_shv = cfg_q[i].shv;
      end
    end
  end

  // Per-source state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      pend_q <= '0;
      src_q  <= '0;
    end else begin
      cfg_q  <= cfg_d;
      pend_q <= pend_d;
      src_q  <= irq_src_i;
    end
  end

  // Registered arbitration result, zeroed when there is no candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clic_irq_o       <= 1'b0;
      clic_irq_id_o    <= '0;
      clic_irq_level_o <= '0;
      clic_irq_shv_o   <= 1'b0;
    end else begin
      clic_irq_o       <= win_vld;
      clic_irq_id_o    <= win_vld ? win_id  : '0;
      clic_irq_level_o <= win_vld ? win_lvl : '0;
      clic_irq_shv_o   <= win_vld & win_shv;
    end
  end

  assign clic_irq_priv_o = CLIC_PRIV_M;

endmodule
